gray_to_bcd_serial_decoder: RTL and testbench
=============================================

Name: gray_to_bcd_serial_decoder

Overview:
Bit-serial decoder for the reverse direction of the BCD-to-Gray path. It receives Gray-coded words MSB first, one bit per accepted strobe, and reconstructs the binary/BCD value with a running XOR. It presents the decoded word on a valid/ready output handshake and flags words outside the BCD range 0..9. It sits on the receive side of the Gray link, feeding downstream BCD logic.

Parameters:
WIDTH, 4, Gray/binary word width in bits; legal range 2..8.
BCD_MAX, 9, largest legal decoded value; any larger value raises bcd_err.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  frame start pulse; arms the decoder for a new word.
bit_valid  input  1  ser_in carries a valid Gray bit this cycle.
ser_in  input  1  serial Gray bit, MSB first.
out_ready  input  1  downstream accepts bin_out this cycle.
out_valid  output  1  bin_out and bcd_err are valid.
bin_out  output  WIDTH  decoded binary word.
bcd_err  output  1  bin_out > BCD_MAX; qualified by out_valid.
busy  output  1  high in SHIFT or HOLD.
step_err  output  1  Gray-step violation; present only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; out_valid=0, bin_out=0, bcd_err=0, busy=0, step_err=0; internal bit counter, shift register and running-XOR bit all cleared.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - start=1 -> SHIFT next cycle; counter=0, accumulator=0, running bit=0.
  - bit_valid is ignored in IDLE, including in the start cycle. The first data bit is sampled no earlier than the cycle after start.
- SHIFT, on each cycle with bit_valid=1:
  - b = running_bit XOR ser_in.
  - Shift b into the accumulator LSB side; running_bit = b; counter++.
  - When the WIDTH-th bit is accepted -> HOLD. bin_out is loaded with the full word and out_valid=1 in the next cycle; latency is 1 cycle after the last bit.
- SHIFT with start=1: abort the current word and restart. Counter, accumulator and running bit are cleared, the state stays SHIFT, and that cycle's bit is discarded.
- HOLD:
  - out_valid=1; bin_out and bcd_err stay stable until the cycle where out_valid and out_ready are both high.
  - On that handshake: next state is IDLE, or SHIFT if start=1 in the same cycle (back-to-back). out_valid drops the next cycle.
  - bit_valid is ignored in HOLD; start without out_ready is ignored.
- bcd_err = (bin_out > BCD_MAX), unsigned compare, registered together with bin_out.
- bin_out keeps its last value after the handshake. It is not cleared until the next word loads or reset.
- busy = (state != IDLE).
- Reset mid-frame discards the partial word; no out_valid is produced for it.

Optional Feature:
Macro: GRAY_STEP_CHECK_EN.
- Defined:
  - The block stores the last handshaken word and a "have_prev" flag (cleared by reset).
  - When a new word enters HOLD with have_prev=1 and |new - prev| != 1 (modulo 2^WIDTH), step_err=1 alongside out_valid.
  - step_err clears on the handshake.
  - Checking starts with the second word after reset.
- Undefined: no storage is built; step_err is constant 0.

Test Plan:
1. Reset, then start, then bits 0,1,1,0 on consecutive cycles -> one cycle later out_valid=1, bin_out=4'b0100, bcd_err=0.
2. Gray 1,1,0,1 -> bin_out=4'b1001 (9), bcd_err=0. Gray 1,1,1,1 -> bin_out=4'b1010 (10), bcd_err=1.
3. Backpressure: decode 0110 with out_ready=0 for 5 cycles -> out_valid and bin_out=0100 held stable. out_ready=1 with start=1 -> next word 1101 decodes to 1001 with no IDLE gap.
4. Abort: start, bits 1,0, then start again, then 0,0,0,1 -> single output bin_out=4'b0001. Drop rst_n after 2 bits of a frame -> all outputs 0 and no out_valid.
5. bit_valid gaps: bits 0,1,1,0 with bit_valid low for 3 cycles between each -> same result 0100. bit_valid in the start cycle -> that bit is ignored.
6. With GRAY_STEP_CHECK_EN: words 0001, 0011, 0111 -> decoded 1, 2, 5; step_err is 0, 0, 1. Without the macro -> step_err is always 0.

Source files
------------

// File: rtl/gray_to_bcd_serial_decoder.sv
// Bit-serial Gray-to-binary decoder, MSB first, with a valid/ready output and a BCD range flag.
// Optional macro GRAY_STEP_CHECK_EN adds a unit-step check between consecutive handshaken words.
module gray_to_bcd_serial_decoder #(
    parameter int WIDTH   = 4,
    parameter int BCD_MAX = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             ser_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin_out,
    output logic             bcd_err,
    output logic             busy,
    output logic             step_err
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             run_q, run_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             err_q, err_d;
    logic             b_w;
    logic [WIDTH-1:0] word_w;

    function automatic logic over_max(input logic [WIDTH-1:0] v);
        return 32'(v) > BCD_MAX;
    endfunction

    // Running XOR turns each Gray bit into the next binary bit
    assign b_w    = run_q ^ ser_in;
    assign word_w = (acc_q << 1) | {{(WIDTH-1){1'b0}}, b_w};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        run_d   = run_q;
        bin_d   = bin_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    acc_d   = '0;
                    run_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (start) begin
                    cnt_d = '0;
                    acc_d = '0;
                    run_d = 1'b0;
                end else if (bit_valid) begin
                    acc_d = word_w;
                    run_d = b_w;
                    if (cnt_q == LAST) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        bin_d   = word_w;
                        err_d   = over_max(word_w);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        acc_d   = '0;
                        run_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            run_q   <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            run_q   <= run_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign bin_out   = bin_q;
    assign bcd_err   = err_q;

`ifdef GRAY_STEP_CHECK_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] prev_q;
    logic             have_prev_q;
    logic             step_q;
    logic             load_w;
    logic             hs_w;
    logic [WIDTH-1:0] diff_w;

    assign load_w = (state_q == SHIFT) && !start && bit_valid && (cnt_q == LAST);
    assign hs_w   = (state_q == HOLD) && out_ready;
    // Wrapping difference: a unit step in either direction is +1 or all-ones
    assign diff_w = word_w - prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            step_q      <= 1'b0;
        end else if (load_w) begin
            step_q <= have_prev_q && (diff_w != ONE) && (diff_w != '1);
        end else if (hs_w) begin
            prev_q      <= bin_q;
            have_prev_q <= 1'b1;
            step_q      <= 1'b0;
        end
    end

    assign step_err = step_q;
`else
    assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_bcd_serial_decoder.sv
// Scoreboard bench for gray_to_bcd_serial_decoder: driver pushes model results, monitor pops on handshake.
module tb_gray_to_bcd_serial_decoder;

    localparam int WIDTH   = 4;
    localparam int BCD_MAX = 9;
    localparam int MOD     = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             bit_valid;
    logic             ser_in;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] bin_out;
    logic             bcd_err;
    logic             busy;
    logic             step_err;

    typedef struct packed {
        logic [WIDTH-1:0] bin;
        logic             err;
        logic             step;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   prev_val = 0;
    bit   have_prev = 1'b0;
    int   cur_bin  = 0;

    gray_to_bcd_serial_decoder #(.WIDTH(WIDTH), .BCD_MAX(BCD_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .ser_in    (ser_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .bin_out   (bin_out),
        .bcd_err   (bcd_err),
        .busy      (busy),
        .step_err  (step_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    endfunction

    // Reference: binary = XOR of the Gray word with all of its right shifts
    function automatic int gray_dec(input int g);
        int r = 0;
        for (int s = 0; s < WIDTH; s++) r ^= (g >> s);
        return r % MOD;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("bin_out", int'(bin_out), int'(e.bin));
                check("bcd_err", int'(bcd_err), int'(e.err));
                check("step_err", int'(step_err), int'(e.step));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input int g);
        exp_t e;
        int   v;
        bit   st;
        v  = gray_dec(g);
        st = 1'b0;
`ifdef GRAY_STEP_CHECK_EN
        st = have_prev && (((v - prev_val + MOD) % MOD) != 1) && (((prev_val - v + MOD) % MOD) != 1);
`endif
        e.bin  = WIDTH'(v);
        e.err  = (v > BCD_MAX);
        e.step = st;
        q.push_back(e);
        cur_bin = v;
    endtask

    task automatic do_start(input bit noise);
        start     = 1'b1;
        bit_valid = noise;
        ser_in    = noise;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic send_bits(input int g, input int gap, input bit rnd);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            bit_valid = 1'b1;
            ser_in    = g[i];
            tick();
            bit_valid = 1'b0;
            ser_in    = $urandom_range(1, 0);
            repeat (rnd ? $urandom_range(gap, 0) : gap) tick();
        end
    endtask

    task automatic handshake(input int bp, input bit nxt_start);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("valid_wait", int'(out_valid), 1);
        for (int i = 0; i < bp; i++) begin
            out_ready = 1'b0;
            start     = ($urandom_range(1, 0) == 1);
            bit_valid = ($urandom_range(1, 0) == 1);
            check("hold_valid", int'(out_valid), 1);
            check("hold_bin", int'(bin_out), cur_bin);
            tick();
        end
        start     = nxt_start;
        bit_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        prev_val  = cur_bin;
        have_prev = 1'b1;
        check("valid_drop", int'(out_valid), 0);
        check("busy_after_hs", int'(busy), int'(nxt_start));
    endtask

    task automatic word(input int g, input int gap, input bit rnd, input int bp);
        do_start(1'b0);
        expect_word(g);
        send_bits(g, gap, rnd);
        handshake(bp, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #3;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_bin_out", int'(bin_out), 0);
        check("rst_bcd_err", int'(bcd_err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_step_err", int'(step_err), 0);
        have_prev = 1'b0;
        prev_val  = 0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bit b2b;
        start     = 1'b0;
        bit_valid = 1'b0;
        ser_in    = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        tick();
        apply_reset();

        // Basic decodes, including the BCD boundary 9 / 10
        word('b0110, 0, 1'b0, 0);
        word('b1101, 0, 1'b0, 0);
        word('b1111, 0, 1'b0, 0);

        // Backpressure then back-to-back word with no IDLE gap
        do_start(1'b0);
        expect_word('b0110);
        send_bits('b0110, 0, 1'b0);
        handshake(5, 1'b1);
        expect_word('b1101);
        send_bits('b1101, 0, 1'b0);
        handshake(0, 1'b0);

        // Abort in SHIFT: restart discards the partial word and that cycle's bit
        do_start(1'b0);
        bit_valid = 1'b1; ser_in = 1'b1; tick();
        ser_in = 1'b0; tick();
        start = 1'b1; ser_in = 1'b1; tick();
        start = 1'b0; bit_valid = 1'b0;
        expect_word('b0001);
        send_bits('b0001, 0, 1'b0);
        handshake(0, 1'b0);

        // Reset mid-frame after two bits
        do_start(1'b0);
        bit_valid = 1'b1; ser_in = 1'b1; tick();
        ser_in = 1'b1; tick();
        bit_valid = 1'b0;
        apply_reset();
        repeat (3) tick();
        check("no_valid_after_rst", int'(out_valid), 0);

        // bit_valid gaps, and a bit offered in the start cycle
        word('b0110, 3, 1'b0, 0);
        do_start(1'b1);
        expect_word('b0110);
        send_bits('b0110, 0, 1'b0);
        handshake(0, 1'b0);

        // Step sequence from a fresh reset: decoded 1, 2, 5
        apply_reset();
        word('b0001, 0, 1'b0, 0);
        word('b0011, 0, 1'b0, 0);
        word('b0111, 0, 1'b0, 0);

        // Randomized traffic
        b2b = 1'b0;
        for (int w = 0; w < 40; w++) begin
            int g;
            g = $urandom_range(MOD - 1, 0);
            if (!b2b) do_start($urandom_range(1, 0) == 1);
            expect_word(g);
            send_bits(g, 2, 1'b1);
            b2b = (w != 39) && ($urandom_range(1, 0) == 1);
            handshake($urandom_range(3, 0), b2b);
        end

        repeat (3) tick();
        check("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
